mmio_uart_tx: RTL and testbench

//  Memory-mapped UART transmitter on the ktc32 data bus, alongside ram and the LED register.
//  - CPU stores bytes to a DATA address; they queue in a small FIFO.
//  - Bytes are serialised 8N1, LSB first, on a single tx pin.
//  - A STATUS address lets software poll busy, full and overflow.

---
 rtl/ktc32_mmio_pkg.sv | 26 ++
 rtl/uart_tx_fifo.sv | 64 ++++++
 rtl/mmio_uart_tx.sv | 156 +++++++++++++++
 tb/tb_mmio_uart_tx.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ktc32_mmio_pkg.sv
// ============================================================================
// ktc32_mmio_pkg : shared address map, status bit layout and UART TX states
// Revision: 1.0
// ============================================================================
`default_nettype none

package ktc32_mmio_pkg;

   localparam logic [31:0] LED_ADDR         = 32'h0000_0054;
   localparam logic [31:0] UART_DATA_ADDR   = 32'h0000_0058;
   localparam logic [31:0] UART_STATUS_ADDR = 32'h0000_005C;

   localparam int STATUS_BUSY = 0;
   localparam int STATUS_FULL = 1;
   localparam int STATUS_OVF  = 2;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } uart_tx_state_t;

endpackage

`default_nettype wire

// File: rtl/uart_tx_fifo.sv
// ============================================================================
// uart_tx_fifo : flop-based byte FIFO; push ignored when full, pop when empty
// Revision: 1.0
// ============================================================================
`default_nettype none

module uart_tx_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int c_AW = $clog2(DEPTH);
   localparam logic [c_AW:0] c_FULL = DEPTH[c_AW:0];

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [c_AW-1:0]  r_wr_ptr;
   logic [c_AW-1:0]  r_rd_ptr;
   logic [c_AW:0]    r_count;
   logic             w_do_push;
   logic             w_do_pop;

   assign full      = (r_count == c_FULL);
   assign empty     = (r_count == '0);
   assign dout      = r_mem[r_rd_ptr];
   assign w_do_push = push && !full;
   assign w_do_pop  = pop && !empty;

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) begin
            r_mem[r_wr_ptr] <= din;
            r_wr_ptr        <= r_wr_ptr + 1'b1;
         end
         if (w_do_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         if (w_do_push && !w_do_pop) begin
            r_count <= r_count + 1'b1;
         end else if (w_do_pop && !w_do_push) begin
            r_count <= r_count - 1'b1;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/mmio_uart_tx.sv
// ============================================================================
// mmio_uart_tx : memory-mapped 8N1 UART transmitter with byte FIFO and status
// Revision: 1.0
// ============================================================================
`default_nettype none

module mmio_uart_tx #(
   parameter int CLKS_PER_BIT = 104,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        memwrite,
   input  logic [31:0] addr,
   input  logic [31:0] wd,
   output logic [31:0] rd_data,
   output logic        hit,
   output logic        tx
);

   import ktc32_mmio_pkg::*;

   localparam logic [15:0] c_BAUD_LAST = 16'(CLKS_PER_BIT - 1);

   logic           w_sel_data;
   logic           w_sel_status;
   logic           w_push;
   logic           w_pop;
   logic           w_full;
   logic           w_empty;
   logic           w_busy;
   logic           w_baud_done;
   logic [7:0]     w_fifo_dout;
   logic           w_unused;

   uart_tx_state_t r_state;
   logic [15:0]    r_baud;
   logic [2:0]     r_bit;
   logic [7:0]     r_shift;
   logic           r_tx;
   logic           r_ovf;

   assign w_sel_data   = (addr == UART_DATA_ADDR);
   assign w_sel_status = (addr == UART_STATUS_ADDR);
   assign w_push       = memwrite && w_sel_data && !w_full;
   assign w_baud_done  = (r_baud == c_BAUD_LAST);
   assign w_pop        = !w_empty && ((r_state == IDLE) || ((r_state == STOP) && w_baud_done));
   assign w_busy       = !w_empty || (r_state != IDLE);
   assign w_unused     = ^wd[31:8];

   assign hit = w_sel_data || w_sel_status;
   assign tx  = r_tx;

   always_comb begin
      rd_data = '0;
      if (w_sel_status) begin
         rd_data[STATUS_BUSY] = w_busy;
         rd_data[STATUS_FULL] = w_full;
         rd_data[STATUS_OVF]  = r_ovf;
      end
   end

   uart_tx_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (reset),
      .push  (w_push),
      .din   (wd[7:0]),
      .pop   (w_pop),
      .dout  (w_fifo_dout),
      .full  (w_full),
      .empty (w_empty)
   );

   // A fresh overflow outranks a same-edge software clear.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_ovf <= 1'b0;
      end else if (memwrite && w_sel_data && w_full) begin
         r_ovf <= 1'b1;
      end else if (memwrite && w_sel_status && wd[STATUS_OVF]) begin
         r_ovf <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
         r_baud  <= '0;
         r_bit   <= '0;
         r_shift <= '0;
         r_tx    <= 1'b1;
      end else begin
         case (r_state)
            IDLE: begin
               r_tx   <= 1'b1;
               r_baud <= '0;
               if (!w_empty) begin
                  r_shift <= w_fifo_dout;
                  r_state <= START;
                  r_tx    <= 1'b0;
               end
            end
            START: begin
               if (w_baud_done) begin
                  r_baud  <= '0;
                  r_bit   <= '0;
                  r_state <= DATA;
                  r_tx    <= r_shift[0];
               end else begin
                  r_baud <= r_baud + 16'd1;
               end
            end
            DATA: begin
               if (w_baud_done) begin
                  r_baud  <= '0;
                  r_shift <= {1'b0, r_shift[7:1]};
                  if (r_bit == 3'd7) begin
                     r_state <= STOP;
                     r_tx    <= 1'b1;
                  end else begin
                     r_bit <= r_bit + 3'd1;
                     r_tx  <= r_shift[1];
                  end
               end else begin
                  r_baud <= r_baud + 16'd1;
               end
            end
            STOP: begin
               if (w_baud_done) begin
                  r_baud <= '0;
                  // Chain straight into the next start bit when more data waits.
                  if (!w_empty) begin
                     r_shift <= w_fifo_dout;
                     r_state <= START;
                     r_tx    <= 1'b0;
                  end else begin
                     r_state <= IDLE;
                  end
               end else begin
                  r_baud <= r_baud + 16'd1;
               end
            end
            default: begin
               r_state <= IDLE;
               r_tx    <= 1'b1;
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_mmio_uart_tx.sv
// ============================================================================
// tb_mmio_uart_tx : scoreboard bench; a serial monitor decodes every frame
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mmio_uart_tx;

   import ktc32_mmio_pkg::*;

   localparam int CPB   = 4;
   localparam int FRAME = 10 * CPB;

   logic        clk      = 1'b0;
   logic        reset    = 1'b1;
   logic        memwrite = 1'b0;
   logic [31:0] addr     = '0;
   logic [31:0] wd       = '0;
   logic [31:0] rd_data;
   logic        hit;
   logic        tx;

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [7:0]  exp_q[$];
   longint      start_cyc[$];
   longint      cyc = 0;

   mmio_uart_tx #(
      .CLKS_PER_BIT (CPB),
      .FIFO_DEPTH   (4)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .memwrite (memwrite),
      .addr     (addr),
      .wd       (wd),
      .rd_data  (rd_data),
      .hit      (hit),
      .tx       (tx)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1);
   end

   // Serial monitor: captures 40 samples per frame and checks shape and byte.
   initial begin : monitor
      logic [FRAME-1:0] s;
      logic [7:0]       got;
      logic [7:0]       exp;
      bit               aborted;
      bit               shape_ok;
      forever begin
         @(negedge clk);
         if (!reset && tx === 1'b0) begin
            aborted = 1'b0;
            s       = '0;
            s[0]    = tx;
            start_cyc.push_back(cyc);
            for (int k = 1; k < FRAME; k++) begin
               @(negedge clk);
               if (reset) begin
                  aborted = 1'b1;
                  break;
               end
               s[k] = tx;
            end
            if (aborted) begin
               if (exp_q.size() > 0) exp_q.delete(0);
            end else begin
               shape_ok = 1'b1;
               for (int b = 0; b < 10; b++)
                  for (int j = 0; j < CPB; j++)
                     if (s[b*CPB+j] !== s[b*CPB]) shape_ok = 1'b0;
               if (s[0] !== 1'b0 || s[FRAME-1] !== 1'b1) shape_ok = 1'b0;
               for (int i = 0; i < 8; i++) got[i] = s[(i+1)*CPB];
               n_checks++;
               if (!shape_ok) begin
                  n_fail++;
                  $display("FAIL frame_shape: samples %b, required low start, stable bits, high stop", s);
               end
               n_checks++;
               if (exp_q.size() == 0) begin
                  n_fail++;
                  $display("FAIL unexpected_frame: got byte %h, required no frame", got);
               end else begin
                  exp = exp_q.pop_front();
                  if (got !== exp) begin
                     n_fail++;
                     $display("FAIL frame_byte: got %h, required %h", got, exp);
                  end
               end
            end
         end
      end
   end

   task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
      memwrite = 1'b1;
      addr     = a;
      wd       = d;
      @(negedge clk);
      memwrite = 1'b0;
      addr     = '0;
      wd       = '0;
   endtask

   task automatic rd_status(output logic [31:0] v);
      addr = UART_STATUS_ADDR;
      #1;
      v = rd_data;
   endtask

   task automatic wait_drain(input string name);
      logic [31:0] v;
      int          i;
      v = '0;
      for (i = 0; i < 2000; i++) begin
         @(negedge clk);
         rd_status(v);
         if (v[STATUS_BUSY] == 1'b0 && exp_q.size() == 0) break;
      end
      n_checks++;
      if (i == 2000) begin
         n_fail++;
         $display("FAIL %s_drain: status %h pending %0d, required idle and 0 pending", name, v, exp_q.size());
      end
   endtask

   task automatic test_reset();
      logic [31:0] v;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      n_checks++;
      if (tx !== 1'b1) begin n_fail++; $display("FAIL reset_tx: got %b, required 1", tx); end
      rd_status(v);
      n_checks++;
      if (v !== 32'h0) begin n_fail++; $display("FAIL reset_status: got %h, required 00000000", v); end
      n_checks++;
      if (hit !== 1'b1) begin n_fail++; $display("FAIL hit_status: got %b, required 1", hit); end
      addr = UART_DATA_ADDR; #1;
      n_checks++;
      if (hit !== 1'b1 || rd_data !== 32'h0) begin
         n_fail++; $display("FAIL hit_data: got hit %b rd %h, required 1 00000000", hit, rd_data);
      end
      addr = LED_ADDR; #1;
      n_checks++;
      if (hit !== 1'b0) begin n_fail++; $display("FAIL hit_led: got %b, required 0", hit); end
      addr = 32'h0; #1;
      n_checks++;
      if (hit !== 1'b0) begin n_fail++; $display("FAIL hit_zero: got %b, required 0", hit); end
   endtask

   task automatic test_single();
      logic [31:0] v;
      @(negedge clk);
      start_cyc.delete();
      exp_q.push_back(8'hA5);
      bus_write(UART_DATA_ADDR, 32'hFFFF_FFA5);
      n_checks++;
      if (tx !== 1'b1) begin n_fail++; $display("FAIL single_pre_start: got %b, required 1", tx); end
      @(negedge clk);
      n_checks++;
      if (tx !== 1'b0) begin n_fail++; $display("FAIL single_start_latency: got %b, required 0", tx); end
      repeat (FRAME - 1) @(negedge clk);
      rd_status(v);
      n_checks++;
      if (v !== 32'h1) begin n_fail++; $display("FAIL single_busy_last: got %h, required 00000001", v); end
      @(negedge clk);
      rd_status(v);
      n_checks++;
      if (v !== 32'h0) begin n_fail++; $display("FAIL single_busy_clear: got %h, required 00000000", v); end
      wait_drain("single");
   endtask

   task automatic test_back_to_back();
      logic [31:0] v;
      bool_gap_check : begin
         bit gap_ok;
         @(negedge clk);
         start_cyc.delete();
         for (int i = 1; i <= 5; i++) begin
            exp_q.push_back(8'(i));
            bus_write(UART_DATA_ADDR, 32'(i));
         end
         rd_status(v);
         n_checks++;
         if (v[STATUS_OVF] !== 1'b0 || v[STATUS_FULL] !== 1'b1) begin
            n_fail++; $display("FAIL b2b_fill: got status %h, required full=1 ovf=0", v);
         end
         wait_drain("b2b");
         gap_ok = (start_cyc.size() == 5);
         if (gap_ok)
            for (int i = 1; i < 5; i++)
               if (start_cyc[i] - start_cyc[i-1] != FRAME) gap_ok = 1'b0;
         n_checks++;
         if (!gap_ok) begin
            n_fail++; $display("FAIL b2b_gap: got %0d frames or uneven spacing, required 5 frames %0d apart", start_cyc.size(), FRAME);
         end
      end
      exp_q.push_back(8'hA0);
      bus_write(UART_DATA_ADDR, 32'hA0);
      repeat (2) @(negedge clk);
      for (int k = 0; k < 6; k++) begin
         if (k < 4) exp_q.push_back(8'hB1 + 8'(k));
         bus_write(UART_DATA_ADDR, 32'hB1 + 32'(k));
      end
      rd_status(v);
      n_checks++;
      if (v !== 32'h7) begin n_fail++; $display("FAIL overflow_status: got %h, required 00000007", v); end
      wait_drain("overflow");
   endtask

   task automatic test_ovf_clear();
      logic [31:0] v;
      @(negedge clk);
      rd_status(v);
      n_checks++;
      if (v !== 32'h4) begin n_fail++; $display("FAIL ovf_sticky: got %h, required 00000004", v); end
      @(negedge clk);
      bus_write(UART_STATUS_ADDR, 32'hFFFF_FFFB);
      rd_status(v);
      n_checks++;
      if (v !== 32'h4) begin n_fail++; $display("FAIL ovf_no_clear: got %h, required 00000004", v); end
      @(negedge clk);
      bus_write(UART_STATUS_ADDR, 32'h4);
      rd_status(v);
      n_checks++;
      if (v !== 32'h0) begin n_fail++; $display("FAIL ovf_w1c: got %h, required 00000000", v); end
      @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         exp_q.push_back(8'hC0 + 8'(i));
         bus_write(UART_DATA_ADDR, 32'hC0 + 32'(i));
      end
      // Overflow write also carries bit 2 set: it must still set ovf.
      bus_write(UART_DATA_ADDR, 32'h0000_00C7);
      rd_status(v);
      n_checks++;
      if (v !== 32'h7) begin n_fail++; $display("FAIL ovf_set_wins: got %h, required 00000007", v); end
      @(negedge clk);
      bus_write(UART_STATUS_ADDR, 32'h4);
      rd_status(v);
      n_checks++;
      if (v !== 32'h3) begin n_fail++; $display("FAIL ovf_clear_busy: got %h, required 00000003", v); end
      wait_drain("ovf");
   endtask

   task automatic test_reset_mid();
      logic [31:0] v;
      @(negedge clk);
      start_cyc.delete();
      exp_q.push_back(8'h3C);
      exp_q.push_back(8'h5A);
      exp_q.push_back(8'h66);
      bus_write(UART_DATA_ADDR, 32'h3C);
      bus_write(UART_DATA_ADDR, 32'h5A);
      bus_write(UART_DATA_ADDR, 32'h66);
      repeat (4) @(negedge clk);
      n_checks++;
      if (tx !== 1'b0) begin n_fail++; $display("FAIL mid_pre_reset: got %b, required 0", tx); end
      #2 reset = 1'b1;
      #1;
      n_checks++;
      if (tx !== 1'b1) begin n_fail++; $display("FAIL mid_async_tx: got %b, required 1", tx); end
      repeat (2) @(negedge clk);
      reset = 1'b0;
      exp_q.delete();
      rd_status(v);
      n_checks++;
      if (v !== 32'h0) begin n_fail++; $display("FAIL mid_status: got %h, required 00000000", v); end
      repeat (100) @(negedge clk);
      n_checks++;
      if (start_cyc.size() != 1 || tx !== 1'b1) begin
         n_fail++; $display("FAIL mid_no_resend: got %0d frames tx %b, required 1 frame tx 1", start_cyc.size(), tx);
      end
   endtask

   task automatic test_push_pop_same_edge();
      logic [31:0] v;
      @(negedge clk);
      exp_q.push_back(8'h11);
      exp_q.push_back(8'h22);
      exp_q.push_back(8'h33);
      bus_write(UART_DATA_ADDR, 32'h11);
      bus_write(UART_DATA_ADDR, 32'h22);
      bus_write(UART_DATA_ADDR, 32'h33);
      // Land the next push on the stop-bit end edge, where the FSM pops.
      repeat (FRAME - 2) @(negedge clk);
      exp_q.push_back(8'h44);
      bus_write(UART_DATA_ADDR, 32'h44);
      exp_q.push_back(8'h55);
      bus_write(UART_DATA_ADDR, 32'h55);
      rd_status(v);
      n_checks++;
      if (v !== 32'h1) begin n_fail++; $display("FAIL pushpop_count3: got %h, required 00000001", v); end
      @(negedge clk);
      exp_q.push_back(8'h66);
      bus_write(UART_DATA_ADDR, 32'h66);
      rd_status(v);
      n_checks++;
      if (v !== 32'h3) begin n_fail++; $display("FAIL pushpop_count4: got %h, required 00000003", v); end
      wait_drain("pushpop");
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_ovf_clear();
      test_reset_mid();
      test_push_pop_same_edge();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
